// File: rtl/hmac_pkg.sv
// Shared definitions for the cached HMAC-SHA512 engine: SHA-512 constants,
// HMAC pad bytes, controller state encoding and the single-block pad helper.
package hmac_pkg;

    localparam logic [7:0] IPAD = 8'h36;
    localparam logic [7:0] OPAD = 8'h5c;

    localparam logic [511:0] H0 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [63:0] K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef enum logic [3:0] {
        ST_IDLE, ST_IPAD_0, ST_IPAD_R, ST_OPAD_0, ST_OPAD_R,
        ST_MSG_0, ST_MSG_R, ST_SUM_0, ST_SUM_R, ST_OUT
    } hmac_state_e;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x);
        return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x);
        return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x);
        return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x);
        return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    endfunction

    // Builds the final padded block of a message whose first prefix_bytes were
    // already absorbed in earlier blocks. Bytes of data at or beyond len_bytes
    // are masked to zero; the length field counts prefix plus data in bits.
    function automatic logic [1023:0] sha512_pad_block(input logic [1023:0] data,
                                                       input logic [7:0]    len_bytes,
                                                       input logic [7:0]    prefix_bytes);
        logic [1023:0] blk;
        logic [15:0]   bits;
        blk = '0;
        for (int i = 0; i < 128; i++) begin
            if (8'(i) < len_bytes) begin
                blk[1023-8*i -: 8] = data[1023-8*i -: 8];
            end else if (8'(i) == len_bytes) begin
                blk[1023-8*i -: 8] = 8'h80;
            end else begin
                blk[1023-8*i -: 8] = 8'h00;
            end
        end
        bits = 16'((16'(prefix_bytes) + 16'(len_bytes)) << 3);
        blk[15:0] = bits;
        return blk;
    endfunction

endpackage

// File: rtl/sha512_chunk.sv
// One SHA-512 compression: loads chaining state and block while init_n_i is
// low, then runs one round per cycle and presents done_o with the result.
module sha512_chunk
    import hmac_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_n_i,
    input  logic [1023:0] chunk_i,
    input  logic [511:0]  ih_i,
    output logic          done_o,
    output logic [511:0]  oh_o
);

    logic [63:0]  v_q [8];
    logic [63:0]  v_d [8];
    logic [63:0]  w_q [16];
    logic [63:0]  w_d [16];
    logic [511:0] hin_q, hin_d;
    logic [6:0]   round_q, round_d;
    logic [63:0]  k_s, t1_s, t2_s, w_new_s;

    // Round datapath: load on init, otherwise one round per cycle until 80
    always_comb begin
        k_s     = (round_q < 7'd80) ? K[round_q] : 64'd0;
        t1_s    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_s + w_q[0];
        t2_s    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new_s = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        v_d     = v_q;
        w_d     = w_q;
        hin_d   = hin_q;
        round_d = round_q;
        if (!init_n_i) begin
            for (int i = 0; i < 8; i++)  v_d[i] = ih_i[511-64*i -: 64];
            for (int i = 0; i < 16; i++) w_d[i] = chunk_i[1023-64*i -: 64];
            hin_d   = ih_i;
            round_d = 7'd0;
        end else if (round_q != 7'd80) begin
            v_d[0] = t1_s + t2_s;
            v_d[1] = v_q[0];
            v_d[2] = v_q[1];
            v_d[3] = v_q[2];
            v_d[4] = v_q[3] + t1_s;
            v_d[5] = v_q[4];
            v_d[6] = v_q[5];
            v_d[7] = v_q[6];
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_new_s;
            round_d = round_q + 7'd1;
        end else begin
            round_d = round_q;
        end
    end

    // Feed-forward of the chaining value once all rounds are complete
    always_comb begin
        oh_o = '0;
        for (int i = 0; i < 8; i++) oh_o[511-64*i -: 64] = hin_q[511-64*i -: 64] + v_q[i];
    end

    assign done_o = (round_q == 7'd80);

    // Working-variable, schedule and round-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)  v_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            hin_q   <= '0;
            round_q <= 7'd0;
        end else begin
            v_q     <= v_d;
            w_q     <= w_d;
            hin_q   <= hin_d;
            round_q <= round_d;
        end
    end

endmodule

// File: rtl/hmac_sha512_cached.sv
// HMAC-SHA512 controller with cached ipad/opad chaining states: a cached run
// costs two compressions (message, outer sum); a rekey run adds two more.
module hmac_sha512_cached
    import hmac_pkg::*;
#(
    parameter int MSG_MAX_BYTES = 64,
    parameter int LEN_W         = 7
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       rekey,
    input  logic [1023:0]              key,
    input  logic [8*MSG_MAX_BYTES-1:0] msg,
    input  logic [LEN_W-1:0]           msg_len,
    output logic                       ready,
    output logic                       done,
    output logic                       cache_valid,
    output logic [511:0]               out
);

    localparam int MSG_PAD_W = 1024 - 8*MSG_MAX_BYTES;

    hmac_state_e   state_q, state_d;
    logic [1023:0] key_q, msg_q;
    logic [7:0]    len_q, len_sat_s;
    logic [511:0]  ist_q, ost_q, isum_q, out_q;
    logic          ready_q, done_q, cache_valid_q;
    logic          accept_s, eff_rekey_s;
    logic          core_init_n_s, core_done_s;
    logic [1023:0] core_chunk_s;
    logic [511:0]  core_ih_s, core_oh_s;

    assign accept_s    = start & ready_q;
    assign eff_rekey_s = rekey | ~cache_valid_q;

    assign ready       = ready_q;
    assign done        = done_q;
    assign cache_valid = cache_valid_q;
    assign out         = out_q;

    // Clamp the requested length to the widest message the block can hold
    always_comb begin
        if (msg_len > LEN_W'(MSG_MAX_BYTES)) begin
            len_sat_s = 8'(MSG_MAX_BYTES);
        end else begin
            len_sat_s = 8'(msg_len);
        end
    end

    // Next state and compression-core operand selection
    always_comb begin
        state_d       = state_q;
        core_init_n_s = 1'b0;
        core_chunk_s  = '0;
        core_ih_s     = H0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = eff_rekey_s ? ST_IPAD_0 : ST_MSG_0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IPAD_0: begin
                core_chunk_s = key_q ^ {128{IPAD}};
                state_d      = ST_IPAD_R;
            end
            ST_IPAD_R: begin
                core_init_n_s = 1'b1;
                state_d       = core_done_s ? ST_OPAD_0 : ST_IPAD_R;
            end
            ST_OPAD_0: begin
                core_chunk_s = key_q ^ {128{OPAD}};
                state_d      = ST_OPAD_R;
            end
            ST_OPAD_R: begin
                core_init_n_s = 1'b1;
                state_d       = core_done_s ? ST_MSG_0 : ST_OPAD_R;
            end
            ST_MSG_0: begin
                core_ih_s    = ist_q;
                core_chunk_s = sha512_pad_block(msg_q, len_q, 8'd128);
                state_d      = ST_MSG_R;
            end
            ST_MSG_R: begin
                core_init_n_s = 1'b1;
                state_d       = core_done_s ? ST_SUM_0 : ST_MSG_R;
            end
            ST_SUM_0: begin
                core_ih_s    = ost_q;
                core_chunk_s = sha512_pad_block({isum_q, 512'd0}, 8'd64, 8'd128);
                state_d      = ST_SUM_R;
            end
            ST_SUM_R: begin
                core_init_n_s = 1'b1;
                state_d       = core_done_s ? ST_OUT : ST_SUM_R;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, captured request and cached chaining states
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            msg_q         <= '0;
            len_q         <= 8'd0;
            ist_q         <= '0;
            ost_q         <= '0;
            isum_q        <= '0;
            out_q         <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            done_q  <= (state_q == ST_SUM_R) && core_done_s;
            if (accept_s) begin
                msg_q <= {msg, {MSG_PAD_W{1'b0}}};
                len_q <= len_sat_s;
                if (eff_rekey_s) begin
                    key_q         <= key;
                    cache_valid_q <= 1'b0;
                end
            end
            if (core_done_s) begin
                case (state_q)
                    ST_IPAD_R: ist_q <= core_oh_s;
                    ST_OPAD_R: begin
                        ost_q         <= core_oh_s;
                        cache_valid_q <= 1'b1;
                    end
                    ST_MSG_R:  isum_q <= core_oh_s;
                    ST_SUM_R:  out_q  <= core_oh_s;
                    default:   ;
                endcase
            end
        end
    end

    sha512_chunk u_core (
        .clk      (clk),
        .rst_n    (reset),
        .init_n_i (core_init_n_s),
        .chunk_i  (core_chunk_s),
        .ih_i     (core_ih_s),
        .done_o   (core_done_s),
        .oh_o     (core_oh_s)
    );

endmodule

// File: tb/tb_hmac_sha512_cached.sv
// Randomised bench for hmac_sha512_cached against a byte-queue SHA-512/HMAC model.
module tb_hmac_sha512_cached;

    localparam int MAXB       = 111;
    localparam int C          = 81;
    localparam int LAT_CACHED = 2*(1+C)+2;
    localparam int LAT_REKEY  = 4*(1+C)+2;
    localparam logic [511:0] KAT1 = 512'h87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854;
    localparam logic [511:0] KAT2 = 512'h164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737;

    typedef logic [7:0] byteq_t [$];

    logic          clk = 1'b0;
    logic          reset, start, rekey;
    logic [1023:0] key;
    logic [887:0]  msg;
    logic [6:0]    msg_len;
    logic          ready, done, cache_valid;
    logic [511:0]  out;

    int            errors = 0;
    int            checks = 0;
    logic [1023:0] m_key = '0;
    logic          m_valid = 1'b0;

    hmac_sha512_cached #(.MSG_MAX_BYTES(MAXB), .LEN_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .rekey(rekey), .key(key),
        .msg(msg), .msg_len(msg_len), .ready(ready), .done(done),
        .cache_valid(cache_valid), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Plain SHA-512 over an arbitrary byte string
    function automatic logic [511:0] ref_sha512(input byteq_t m);
        byteq_t      p;
        logic [63:0] hv [8];
        logic [63:0] w [80];
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2, bitlen;
        p = m;
        bitlen = 64'(m.size()) << 3;
        p.push_back(8'h80);
        while ((p.size() % 128) != 112) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        for (int i = 0; i < 8; i++) hv[i] = hmac_pkg::H0[511-64*i -: 64];
        for (int blk = 0; blk < p.size() / 128; blk++) begin
            for (int t = 0; t < 16; t++) begin
                w[t] = '0;
                for (int j = 0; j < 8; j++) w[t] = {w[t][55:0], p[blk*128 + t*8 + j]};
            end
            for (int t = 16; t < 80; t++)
                w[t] = (rr(w[t-2], 19) ^ rr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                     + (rr(w[t-15], 1) ^ rr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
            a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
            e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
            for (int t = 0; t < 80; t++) begin
                t1 = h + (rr(e, 14) ^ rr(e, 18) ^ rr(e, 41)) + ((e & f) ^ (~e & g)) + hmac_pkg::K[t] + w[t];
                t2 = (rr(a, 28) ^ rr(a, 34) ^ rr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
            hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    // HMAC = H((K ^ opad) || H((K ^ ipad) || msg)) with a 128-byte key block
    function automatic logic [511:0] hmac_ref(input logic [1023:0] k, input byteq_t mb);
        byteq_t       iq, oq;
        logic [511:0] ih;
        for (int i = 0; i < 128; i++) iq.push_back(k[1023-8*i -: 8] ^ 8'h36);
        foreach (mb[i]) iq.push_back(mb[i]);
        ih = ref_sha512(iq);
        for (int i = 0; i < 128; i++) oq.push_back(k[1023-8*i -: 8] ^ 8'h5c);
        for (int i = 0; i < 64; i++) oq.push_back(ih[511-8*i -: 8]);
        return ref_sha512(oq);
    endfunction

    function automatic byteq_t msg_bytes(input logic [887:0] m, input logic [6:0] len);
        byteq_t q;
        int     n;
        n = (int'(len) > MAXB) ? MAXB : int'(len);
        for (int i = 0; i < n; i++) q.push_back(m[887-8*i -: 8]);
        return q;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r = {r[991:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [887:0] str_msg(input string s);
        logic [887:0] m;
        m = '0;
        for (int i = 0; i < s.len(); i++) m[887-8*i -: 8] = s[i];
        return m;
    endfunction

    // Issues one request, scrambles inputs right after capture, waits for done.
    // lat counts cycles inclusively from the start cycle to the done cycle.
    task automatic run_hmac(input logic [1023:0] k, input logic [887:0] m, input logic [6:0] len,
                            input logic rk, output int lat);
        int            guard;
        logic [1023:0] g;
        guard = 0;
        while (!ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", 512'(ready), 512'(1'b1));
        key = k; msg = m; msg_len = len; rekey = rk; start = 1'b1;
        lat = 1;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 2) begin
                start = 1'b0;
                g = rnd1024();
                key = g;
                g = rnd1024();
                msg = g[1023:136];
                msg_len = 7'($urandom_range(0, 127));
                rekey = 1'($urandom_range(0, 1));
            end
        end while (!done && lat < 1000);
        check("done_seen", 512'(done), 512'(1'b1));
    endtask

    task automatic do_case(input string tag, input logic [1023:0] k, input logic [887:0] m,
                           input logic [6:0] len, input logic rk, output logic [511:0] got);
        logic         eff;
        logic [511:0] exp;
        int           lat;
        eff = rk || !m_valid;
        if (eff) m_key = k;
        exp = hmac_ref(m_key, msg_bytes(m, len));
        run_hmac(k, m, len, rk, lat);
        got = out;
        check({tag, "_out"}, out, exp);
        check({tag, "_lat"}, 512'(lat), 512'(eff ? LAT_REKEY : LAT_CACHED));
        m_valid = 1'b1;
        check({tag, "_cv"}, 512'(cache_valid), 512'(1'b1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] k, tmp;
        logic [887:0]  m;
        logic [6:0]    ln;
        logic          rk;
        logic [511:0]  got, exp, last_out;
        int            dn, acc, viol, nb;
        logic          prev_done;

        reset = 1'b0; start = 1'b0; rekey = 1'b0; key = '0; msg = '0; msg_len = 7'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 512'(ready), 512'(1'b1));
        check("rst_done", 512'(done), 512'(1'b0));
        check("rst_cv", 512'(cache_valid), 512'(1'b0));
        check("rst_out", out, 512'd0);

        // Known-answer vectors
        k = '0;
        for (int i = 0; i < 20; i++) k[1023-8*i -: 8] = 8'h0b;
        do_case("tc1", k, str_msg("Hi There"), 7'd8, 1'b1, got);
        check("tc1_kat", got, KAT1);
        k = '0;
        k[1023:992] = 32'h4a656665;
        do_case("tc2", k, str_msg("what do ya want for nothing?"), 7'd28, 1'b1, got);
        check("tc2_kat", got, KAT2);
        tmp = rnd1024();
        do_case("tc2_cached", tmp, str_msg("what do ya want for nothing?"), 7'd28, 1'b0, got);
        check("tc2_cached_kat", got, KAT2);

        // Random messages with garbage tails, boundary lengths and mixed rekeying
        m = '0;
        for (int r = 0; r < 14; r++) begin
            if (r != 2) begin
                tmp = rnd1024();
                m = tmp[1023:136];
            end
            case (r)
                0:       ln = 7'd0;
                1:       ln = 7'd111;
                2:       ln = 7'd116;
                3:       ln = 7'd127;
                default: ln = 7'($urandom_range(1, 110));
            endcase
            rk = (r == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            nb = $urandom_range(1, 128);
            k = rnd1024();
            for (int i = nb; i < 128; i++) k[1023-8*i -: 8] = 8'h00;
            do_case($sformatf("rnd%0d", r), k, m, ln, rk, got);
        end

        // Reset in the middle of the message compression
        tmp = rnd1024();
        m = tmp[1023:136];
        key = rnd1024(); msg = m; msg_len = 7'd40; rekey = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_ready", 512'(ready), 512'(1'b1));
        check("abort_done", 512'(done), 512'(1'b0));
        check("abort_cv", 512'(cache_valid), 512'(1'b0));
        check("abort_out", out, 512'd0);
        m_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("abort_no_done", 512'(dn), 512'd0);
        k = rnd1024();
        do_case("post_abort", k, m, 7'd40, 1'b0, got);

        // start held high through several runs
        tmp = rnd1024();
        m = tmp[1023:136];
        exp = hmac_ref(m_key, msg_bytes(m, 7'd77));
        key = rnd1024(); msg = m; msg_len = 7'd77; rekey = 1'b0; start = 1'b1;
        acc = 0; dn = 0; viol = 0; prev_done = done; last_out = out;
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc == 500) start = 1'b0;
            if (start && ready) acc++;
            @(posedge clk); #1;
            if (done) begin
                dn++;
                check("burst_out", out, exp);
                if (prev_done) viol++;
                last_out = out;
            end else if (out !== last_out) begin
                viol++;
            end
            prev_done = done;
        end
        check("burst_dones", 512'(dn), 512'(acc));
        check("burst_viol", 512'(viol), 512'd0);
        check("burst_acc_min", 512'(acc >= 2), 512'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hmac_sha512_cached.md
Name: hmac_sha512_cached

Overview:
- Parametrised successor to the fixed-mode HMAC-SHA512 engine.
- Accepts a runtime message length from 0 to MSG_MAX_BYTES and zero-masks unused message bytes itself.
- Caches the post-ipad and post-opad chaining states, so repeated HMACs under one key (PBKDF2 iterations) cost 2 compressions instead of 4.
- Sits between the PBKDF2 iteration controller and one sha512_chunk instance.

Parameters:
- MSG_MAX_BYTES, 64, widest message accepted; legal range 1..111, so the inner message always fits one padded block.
- LEN_W, 7, width of msg_len; must satisfy 2**LEN_W > MSG_MAX_BYTES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- rekey  in  1  1 = recompute pad states from key; 0 = reuse cache
- key  in  1024  zero-padded key, byte 0 at bits [1023:1016]
- msg  in  8*MSG_MAX_BYTES  message, byte 0 in the MSBs; bytes at or beyond msg_len are don't-care
- msg_len  in  LEN_W  message length in bytes
- ready  out  1  idle, start will be accepted
- done  out  1  one-cycle pulse when out is updated
- cache_valid  out  1  cached ipad/opad states are usable
- out  out  512  HMAC result, held until the next done

Behaviour:
- Reset (async, active-low): state=IDLE, ready=1, done=0, cache_valid=0, out=0, sha512 core held in reset. Reset mid-operation aborts the operation and invalidates the cache.
- Capture: on start&&ready, register key (only if the effective rekey is 1), msg, and msg_len saturated to MSG_MAX_BYTES. ready drops the next cycle. Inputs may change after capture.
- Effective rekey = rekey || !cache_valid.
- States:
  - IDLE -> IPAD_0 if effective rekey, else MSG_0.
  - IPAD_0: chunk = key ^ {128{8'h36}}, iH = H0.
  - IPAD_R: wait for sha512 done; ist <= oH.
  - OPAD_0: chunk = key ^ {128{8'h5c}}, iH = H0.
  - OPAD_R: wait; ost <= oH; cache_valid <= 1.
  - MSG_0: iH = ist. Chunk byte i = msg byte i for i<len, 0x80 at byte len, zero elsewhere. Bytes 126..127 = (128+len)*8 as 16-bit big-endian.
  - MSG_R: wait; isum <= oH.
  - SUM_0: iH = ost; chunk = isum, 0x80 at byte 64, length 0x0600 in bytes 126..127.
  - SUM_R: wait.
  - OUT: out <= oH, done=1 for this cycle only.
  - OUT -> IDLE.
- Each *_0 state holds the sha512 reset low for exactly 1 cycle. The following *_R state releases it and advances on the core's done.
- Latency, start to done: cached path = 2*(1+C)+2 cycles; rekey path = 4*(1+C)+2 cycles, where C is the sha512_chunk run time.
- Boundaries:
  - msg_len=0: chunk byte 0 = 0x80, length field 0x0400.
  - msg_len=MSG_MAX_BYTES=111: byte 111 = 0x80, no zero bytes between it and the length field.
  - start while busy: ignored, no queuing.
  - start and rekey both 0 with cache_valid=0: treated as rekey.
  - done and ready both asserted in the OUT->IDLE boundary: next start is accepted on the cycle after done.
- The key register changes only on a rekey capture, so a cached run never observes a new key.

Decomposition:
- Shared package hmac_pkg: H0 constants, IPAD=8'h36, OPAD=8'h5c, and a state enum typedef.
- Shared package also holds a function sha512_pad_block(data, len_bytes, prefix_bytes) returning the padded 1024-bit chunk; it is used by both MSG_0 and SUM_0.
- The only submodule is the existing sha512_chunk; no new submodule is needed.

Test Plan:
- Key = 20 bytes of 0x0b, msg = "Hi There", len 8, rekey=1 -> out = 87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854; cache_valid=1 after OPAD_R.
- Key = "Jefe", msg = "what do ya want for nothing?", len 28, rekey=1 -> out = 164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737.
  - Repeat with rekey=0 and garbage on key -> same out, latency shorter by 2*(1+C) cycles.
- Garbage in msg bytes beyond len, len 0 and len MSG_MAX_BYTES -> out matches a software HMAC model; msg_len = MSG_MAX_BYTES+5 -> result identical to the MSG_MAX_BYTES case.
- Reset asserted during MSG_R -> ready=1, cache_valid=0, done never pulses. The next start with rekey=0 takes the rekey path and gives the correct HMAC.
- start pulsed every cycle during a run -> exactly one done per accepted start; done is high for exactly 1 cycle; out is stable between done pulses.
